// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch debouncer.
// Macro DEBOUNCE_SYNC_EN selects a two-flop input synchronizer.
// Without it, a single sampling flop is used, for inputs already synchronous to Clock.
package switch_debouncer_pkg;

  // Stability counter width for real hardware (about 105 ms at 10 MHz).
  localparam int unsigned DEBOUNCE_WIDTH_DEFAULT = 20;
  // Short width so simulations reach a committed edge quickly.
  localparam int unsigned DEBOUNCE_WIDTH_SIM     = 2;

`ifdef DEBOUNCE_SYNC_EN
  localparam int unsigned DEBOUNCE_SYNC_DEPTH = 2;
`else
  localparam int unsigned DEBOUNCE_SYNC_DEPTH = 1;
`endif

  // Edge event produced when the debounced level commits.
  typedef enum logic [1:0] {
    EdgeNone = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10
  } edge_e;

  // Classify the transition from the current level to the newly committed one.
  function automatic edge_e edge_of(input logic old_lvl, input logic new_lvl);
    if (!old_lvl && new_lvl) begin
      return EdgeRise;
    end else if (old_lvl && !new_lvl) begin
      return EdgeFall;
    end
    return EdgeNone;
  endfunction

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Parameterizable-depth flop chain for a single-bit signal.
// Depth 2 is a metastability synchronizer; Depth 1 is a plain sampling flop.
// All stages clear on a synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_d, sync_q;

  // Shift the input one stage down the chain each cycle.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = d_i;
    for (int i = 1; i < int'(Depth); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: turns a noisy asynchronous pin into a clean level plus
// one-cycle Rise/Fall pulses. The level only changes after the sampled input
// has disagreed with it for 2^Width consecutive enabled cycles.
// Macro DEBOUNCE_SYNC_EN: defined gives a two-flop synchronizer, undefined a
// single sampling flop (one edge less latency).
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned Width = DEBOUNCE_WIDTH_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic In,
  output logic Out,
  output logic Rise,
  output logic Fall
);

  localparam logic [Width-1:0] CntOne = Width'(1);
  localparam logic [Width-1:0] CntMax = '1;

  logic             in_sync;
  logic [Width-1:0] cnt_d, cnt_q;
  logic             out_d, out_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  edge_e            edge_ev;

  sync_2ff #(
    .Depth (DEBOUNCE_SYNC_DEPTH)
  ) u_sync (
    .clk_i (Clock),
    .rst_i (Reset),
    .d_i   (In),
    .q_o   (in_sync)
  );

  // Stability counter and level commit; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    out_d   = out_q;
    edge_ev = EdgeNone;
    if (in_sync == out_q) begin
      cnt_d = '0;
    end else if (Enable) begin
      if (cnt_q == CntMax) begin
        // Terminal count commits the new level instead of wrapping.
        out_d   = in_sync;
        cnt_d   = '0;
        edge_ev = edge_of(out_q, in_sync);
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // Edge pulses are registered alongside the level they announce.
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (edge_ev)
      EdgeRise: rise_d = 1'b1;
      EdgeFall: fall_d = 1'b1;
      default: ;
    endcase
  end

  // State register with synchronous active-high clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Out  = out_q;
  assign Rise = rise_q;
  assign Fall = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer. Instance A uses Width=2, instance B
// Width=3; they share clock, reset and enable but have separate inputs.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SyncDepth = 2;
`else
  localparam int SyncDepth = 1;
`endif
  // Edges from the first sampling edge to the committed level.
  localparam int LatA = 4 + SyncDepth;
  localparam int LatB = 8 + SyncDepth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic in_a = 1'b1;
  logic in_b = 1'b0;
  logic out_a, rise_a, fall_a;
  logic out_b, rise_b, fall_b;
  logic sel_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .Width (DEBOUNCE_WIDTH_SIM)
  ) u_dut_a (
    .Clock  (clk),
    .Reset  (rst),
    .Enable (en),
    .In     (in_a),
    .Out    (out_a),
    .Rise   (rise_a),
    .Fall   (fall_a)
  );

  switch_debouncer #(
    .Width (3)
  ) u_dut_b (
    .Clock  (clk),
    .Reset  (rst),
    .Enable (en),
    .In     (in_b),
    .Out    (out_b),
    .Rise   (rise_b),
    .Fall   (fall_b)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Run n edges; the level goes old_v -> new_v on edge lat (lat=0: never).
  // With toggle set, Enable is 1 on odd edges and 0 on even edges.
  task automatic expect_edges(input string tag, input int n, input logic old_v,
                              input logic new_v, input int lat, input bit toggle);
    logic eo, er, ef;
    for (int k = 1; k <= n; k++) begin
      if (toggle) en = (k % 2 == 1);
      @(posedge clk);
      #1;
      eo = (lat > 0 && k >= lat) ? new_v : old_v;
      er = (lat > 0 && k == lat && new_v && !old_v);
      ef = (lat > 0 && k == lat && !new_v && old_v);
      check($sformatf("%s_out_e%0d", tag, k), sel_b ? out_b : out_a, eo);
      check($sformatf("%s_rise_e%0d", tag, k), sel_b ? rise_b : rise_a, er);
      check($sformatf("%s_fall_e%0d", tag, k), sel_b ? fall_b : fall_a, ef);
    end
  endtask

  initial begin
    // Reset held 3 cycles with In=1: everything stays 0.
    expect_edges("rst_hold", 3, 1'b0, 1'b0, 0, 1'b0);
    sel_b = 1'b1;
    check("rst_b_out", out_b, 1'b0);
    sel_b = 1'b0;
    rst = 1'b0;
    expect_edges("rst_release", LatA + 1, 1'b0, 1'b1, LatA, 1'b0);

    // Clean falling step.
    in_a = 1'b0;
    expect_edges("step_fall", LatA + 1, 1'b1, 1'b0, LatA, 1'b0);

    // 3-cycle burst, 1-cycle dropout, then held high.
    in_a = 1'b1;
    expect_edges("glitch_burst", 3, 1'b0, 1'b0, 0, 1'b0);
    in_a = 1'b0;
    expect_edges("glitch_gap", 1, 1'b0, 1'b0, 0, 1'b0);
    in_a = 1'b1;
    expect_edges("glitch_hold", LatA + 1, 1'b0, 1'b1, LatA, 1'b0);
    in_a = 1'b0;
    expect_edges("glitch_back", LatA + 1, 1'b1, 1'b0, LatA, 1'b0);

    // Enable toggling: counting only on odd edges, commit lands on edge 9.
    in_a = 1'b1;
    expect_edges("en_toggle", 10, 1'b0, 1'b1, 9, 1'b1);
    en = 1'b1;
    in_a = 1'b0;
    expect_edges("en_back", LatA + 1, 1'b1, 1'b0, LatA, 1'b0);

    // Width=3: reset for one cycle once cnt reaches 5, then full interval again.
    sel_b = 1'b1;
    in_b = 1'b1;
    expect_edges("w3_count", 5 + SyncDepth, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    expect_edges("w3_reset", 1, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    expect_edges("w3_after", LatB + 1, 1'b0, 1'b1, LatB, 1'b0);
    sel_b = 1'b0;
    check("w3_a_idle", out_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
